dump_engine: RTL and testbench

Reads a completed capture out of the per-channel circular sample RAMs and streams it, one byte per transfer, to the UART transmitter. It is the readout side of the capture path: the sampler/capture logic writes the RAMs at `wrt_smpl`; this block reads them back, oldest sample first, on a host dump command. It sits between the command processor (which issues `dump_start`), the five channel RAMs, and the UART TX.

---
 rtl/la_pkg.sv | 31 +++
 rtl/dump_engine_if.sv | 33 +++
 rtl/dump_addr_ctr.sv | 39 +++
 rtl/dump_engine.sv | 130 +++++++++++++
 tb/tb_dump_engine.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyzer readout path: dump FSM states,
// channel count, header tag and default RAM geometry.
package la_pkg;

    localparam int         NUM_CH      = 5;
    localparam logic [4:0] HDR_TAG     = 5'b10100;
    localparam int         DEF_ENTRIES = 384;
    localparam int         DEF_AW      = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_LAT,
        ST_SEND,
        ST_WAIT_TX,
        ST_DONE
    } dump_state_e;

    function automatic logic chan_valid(input logic [2:0] ch);
        return (ch != 3'd0) && (ch <= 3'd5);
    endfunction

    // Channel numbers are 1-based; bit 0 of the enable vector is CH1.
    function automatic logic [NUM_CH-1:0] chan_onehot(input logic [2:0] ch);
        logic [NUM_CH-1:0] oh;
        oh = '0;
        if (chan_valid(ch)) oh[ch - 3'd1] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/dump_engine_if.sv
// Bundle of the dump engine's command, RAM-read and UART-TX signals.
// master = the dump engine, slave = command processor / RAMs / UART side.
interface dump_engine_if #(
    parameter int AW = la_pkg::DEF_AW
) ();
    logic                      dump_start;
    logic [2:0]                dump_chan;
    logic [AW-1:0]             wr_ptr;
    logic [7:0]                rdataCH1;
    logic [7:0]                rdataCH2;
    logic [7:0]                rdataCH3;
    logic [7:0]                rdataCH4;
    logic [7:0]                rdataCH5;
    logic [AW-1:0]             ram_addr;
    logic [la_pkg::NUM_CH-1:0] ch_rd_en;
    logic [7:0]                tx_data;
    logic                      trmt;
    logic                      tx_done;
    logic                      busy;
    logic                      dump_done;

    modport master (
        input  dump_start, dump_chan, wr_ptr,
        input  rdataCH1, rdataCH2, rdataCH3, rdataCH4, rdataCH5, tx_done,
        output ram_addr, ch_rd_en, tx_data, trmt, busy, dump_done
    );

    modport slave (
        output dump_start, dump_chan, wr_ptr,
        output rdataCH1, rdataCH2, rdataCH3, rdataCH4, rdataCH5, tx_done,
        input  ram_addr, ch_rd_en, tx_data, trmt, busy, dump_done
    );
endinterface

// File: rtl/dump_addr_ctr.sv
// Circular read-address counter (wraps at ENTRIES, not 2**AW) plus a count of
// samples already sent, with a flag on the final sample.
module dump_addr_ctr #(
    parameter int ENTRIES = la_pkg::DEF_ENTRIES,
    parameter int AW      = la_pkg::DEF_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [AW-1:0] load_addr,
    input  logic          inc,
    output logic [AW-1:0] addr,
    output logic          last
);

    localparam logic [AW-1:0] LAST_IDX = AW'(ENTRIES - 1);
    localparam logic [AW-1:0] ONE      = AW'(1);

    logic [AW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
            cnt  <= '0;
        end else if (load) begin
            // A pointer outside the RAM cannot name the oldest sample; start at 0.
            addr <= (load_addr > LAST_IDX) ? '0 : load_addr;
            cnt  <= '0;
        end else if (inc) begin
            addr <= (addr == LAST_IDX) ? '0 : addr + ONE;
            cnt  <= cnt + ONE;
        end
    end

    assign last = (cnt == LAST_IDX);

endmodule

// File: rtl/dump_engine.sv
// Streams one channel's circular capture RAM to the UART, oldest sample first.
// Define DUMP_CHAN_HDR_EN to prefix each dump with a {HDR_TAG, channel} byte.
module dump_engine
    import la_pkg::*;
#(
    parameter int ENTRIES = DEF_ENTRIES,
    parameter int AW      = DEF_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    dump_engine_if.master bus
);

`ifdef DUMP_CHAN_HDR_EN
    localparam logic HDR_EN = 1'b1;
`else
    localparam logic HDR_EN = 1'b0;
`endif

    dump_state_e state_q, state_d;
    logic [2:0]  chan_q;
    logic        hdr_q;
    logic        ctr_load;
    logic        ctr_inc;
    logic        ctr_last;
    logic        accept;
    logic [2:0]  rd_chan;
    logic [7:0]  rdata_sel;

    assign accept  = (state_q == ST_IDLE) && bus.dump_start && chan_valid(bus.dump_chan);
    // On the IDLE->RD edge the channel register is not loaded yet.
    assign rd_chan = (state_q == ST_IDLE) ? bus.dump_chan : chan_q;

    dump_addr_ctr #(
        .ENTRIES (ENTRIES),
        .AW      (AW)
    ) u_addr_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ctr_load),
        .load_addr (bus.wr_ptr),
        .inc       (ctr_inc),
        .addr      (bus.ram_addr),
        .last      (ctr_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first so no path
    // through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        state_d  = state_q;
        ctr_load = 1'b0;
        ctr_inc  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.dump_start) begin
                    if (accept) begin
                        ctr_load = 1'b1;
                        state_d  = HDR_EN ? ST_SEND : ST_RD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RD:   state_d = ST_LAT;
            ST_LAT:  state_d = ST_SEND;
            ST_SEND: state_d = ST_WAIT_TX;
            ST_WAIT_TX: begin
                if (bus.tx_done) begin
                    if (hdr_q) begin
                        state_d = ST_RD;
                    end else if (ctr_last) begin
                        state_d = ST_DONE;
                    end else begin
                        ctr_inc = 1'b1;
                        state_d = ST_RD;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rdata_sel = 8'h00;
        case (chan_q)
            3'd1:    rdata_sel = bus.rdataCH1;
            3'd2:    rdata_sel = bus.rdataCH2;
            3'd3:    rdata_sel = bus.rdataCH3;
            3'd4:    rdata_sel = bus.rdataCH4;
            3'd5:    rdata_sel = bus.rdataCH5;
            default: rdata_sel = 8'h00;
        endcase
    end

    // Outputs are registered from the next state so they line up with the
    // state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chan_q        <= 3'd0;
            hdr_q         <= 1'b0;
            bus.tx_data   <= 8'h00;
            bus.ch_rd_en  <= '0;
            bus.trmt      <= 1'b0;
            bus.busy      <= 1'b0;
            bus.dump_done <= 1'b0;
        end else begin
            if (accept) begin
                chan_q <= bus.dump_chan;
                hdr_q  <= HDR_EN;
            end else if ((state_q == ST_WAIT_TX) && bus.tx_done) begin
                hdr_q <= 1'b0;
            end

            if (accept && HDR_EN) bus.tx_data <= {HDR_TAG, bus.dump_chan};
            else if (state_q == ST_LAT) bus.tx_data <= rdata_sel;

            bus.ch_rd_en  <= (state_d == ST_RD) ? chan_onehot(rd_chan) : '0;
            bus.trmt      <= (state_d == ST_SEND);
            bus.busy      <= (state_d != ST_IDLE);
            bus.dump_done <= (state_d == ST_DONE);
        end
    end

endmodule

// File: tb/tb_dump_engine.sv
// Directed bench for dump_engine: RAM and UART models, per-dump byte/address
// scoreboard, timing and abort checks. Honours DUMP_CHAN_HDR_EN.
module tb_dump_engine;

    localparam int ENTRIES = 384;
    localparam int AW      = 9;
`ifdef DUMP_CHAN_HDR_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dump_engine_if #(.AW(AW)) bus ();

    dump_engine #(.ENTRIES(ENTRIES), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Channel 2 holds addr[7:0]; other channels are tagged in the top bits.
    function automatic logic [7:0] ch_byte(input int ch, input int a);
        logic [7:0] b;
        b = 8'(a);
        return (ch == 2) ? b : (b ^ {3'(ch), 5'b0});
    endfunction

    // Synchronous-read RAMs: data valid the cycle after the enable.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rdataCH1 <= 8'h00; bus.rdataCH2 <= 8'h00; bus.rdataCH3 <= 8'h00;
            bus.rdataCH4 <= 8'h00; bus.rdataCH5 <= 8'h00;
        end else begin
            if (bus.ch_rd_en[0]) bus.rdataCH1 <= ch_byte(1, int'(bus.ram_addr));
            if (bus.ch_rd_en[1]) bus.rdataCH2 <= ch_byte(2, int'(bus.ram_addr));
            if (bus.ch_rd_en[2]) bus.rdataCH3 <= ch_byte(3, int'(bus.ram_addr));
            if (bus.ch_rd_en[3]) bus.rdataCH4 <= ch_byte(4, int'(bus.ram_addr));
            if (bus.ch_rd_en[4]) bus.rdataCH5 <= ch_byte(5, int'(bus.ram_addr));
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0] sent_q[$];
    int         rd_addr_q[$];
    int rd_cnt, trmt_cnt, done_cnt, busy_cyc, bad_onehot, bad_hold;
    int first_rd_cyc, first_trmt_cyc, first_txd_cyc, last_txd_cyc, done_cyc;

    // Drives one dump and records what the DUT does, cycle by cycle.
    // Cycle k = k-th negedge after dump_start was raised.
    task automatic run_dump(input logic [2:0] ch, input int wp, input int hold,
                            input int restart_at, input int abort_at);
        int         pend;
        int         held;
        logic       restarted;
        logic [7:0] cur;
        logic [4:0] exp_oh;
        sent_q.delete();
        rd_addr_q.delete();
        rd_cnt = 0; trmt_cnt = 0; done_cnt = 0; busy_cyc = 0; bad_onehot = 0; bad_hold = 0;
        first_rd_cyc = -1; first_trmt_cyc = -1; first_txd_cyc = -1; last_txd_cyc = -1;
        done_cyc = -1;
        pend = -1; held = 0; restarted = 1'b0; cur = 8'h00;
        exp_oh = 5'b0;
        if (ch >= 3'd1 && ch <= 3'd5) exp_oh[ch - 3'd1] = 1'b1;

        @(negedge clk);
        bus.dump_start = 1'b1;
        bus.dump_chan  = ch;
        bus.wr_ptr     = AW'(wp);
        for (int cyc = 1; cyc <= 5000; cyc++) begin
            @(negedge clk);
            if (bus.busy) busy_cyc++;
            if (bus.ch_rd_en != 5'b0) begin
                rd_cnt++;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                if (bus.ch_rd_en !== exp_oh) bad_onehot++;
                rd_addr_q.push_back(int'(bus.ram_addr));
            end
            if (bus.trmt) begin
                trmt_cnt++;
                if (first_trmt_cyc < 0) first_trmt_cyc = cyc;
                sent_q.push_back(bus.tx_data);
                cur  = bus.tx_data;
                pend = 3;
                held = 0;
            end
            if ((pend >= 0 || bus.tx_done) && bus.tx_data !== cur) bad_hold++;
            if (bus.dump_done) begin
                done_cnt++;
                done_cyc = cyc;
            end

            // Inputs for this cycle; anything set after acceptance must be ignored.
            bus.dump_start = 1'b0;
            if (cyc == 1) begin
                bus.dump_chan = ch ^ 3'd4;
                bus.wr_ptr    = AW'(wp + 7);
            end
            if (restart_at > 0 && trmt_cnt == restart_at && !restarted) begin
                bus.dump_start = 1'b1;
                bus.dump_chan  = 3'd1;
                bus.wr_ptr     = '0;
                restarted      = 1'b1;
            end
            if (bus.trmt) begin
                bus.tx_done = 1'b0;
            end else if (pend == 0) begin
                bus.tx_done = 1'b1;
                if (first_txd_cyc < 0) first_txd_cyc = cyc;
                last_txd_cyc = cyc;
                pend = -1;
                held = 1;
            end else if (pend > 0) begin
                pend--;
            end else if (held > 0) begin
                if (held >= hold) begin
                    bus.tx_done = 1'b0;
                    held = 0;
                end else begin
                    held++;
                end
            end

            if (abort_at > 0 && trmt_cnt == abort_at) begin
                #1 rst_n = 1'b0;
                #1;
                check("abort_outputs_zero",
                      32'({bus.ram_addr, bus.ch_rd_en, bus.tx_data, bus.trmt, bus.busy, bus.dump_done}),
                      32'd0);
                check("abort_no_done", done_cnt, 0);
                bus.tx_done = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (done_cnt > 0 && cyc == done_cyc + 3) break;
        end
        bus.tx_done = 1'b0;
    endtask

    task automatic verify(input string tag, input int ch, input int wp);
        int         wp0;
        int         bad_b;
        int         bad_a;
        logic [7:0] eb;
        wp0   = (wp >= ENTRIES) ? 0 : wp;
        bad_b = 0;
        bad_a = 0;
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_trmt_cnt"}, trmt_cnt, ENTRIES + HDR);
        check({tag, "_rd_cnt"}, rd_cnt, ENTRIES);
        check({tag, "_onehot"}, bad_onehot, 0);
        check({tag, "_tx_hold"}, bad_hold, 0);
        check({tag, "_done_lat"}, done_cyc, last_txd_cyc + 1);
        check({tag, "_busy_len"}, busy_cyc, done_cyc);
`ifdef DUMP_CHAN_HDR_EN
        if (sent_q.size() > 0) check({tag, "_hdr_byte"}, 32'(sent_q[0]), 32'(8'hA0 | 8'(ch)));
        check({tag, "_first_trmt"}, first_trmt_cyc, 1);
        check({tag, "_first_rd"}, first_rd_cyc, first_txd_cyc + 1);
`else
        check({tag, "_first_rd"}, first_rd_cyc, 1);
        check({tag, "_first_trmt"}, first_trmt_cyc, 3);
`endif
        if (sent_q.size() > HDR) check({tag, "_first_byte"}, 32'(sent_q[HDR]), 32'(ch_byte(ch, wp0)));
        for (int i = 0; i < ENTRIES; i++) begin
            eb = ch_byte(ch, (wp0 + i) % ENTRIES);
            if (HDR + i < sent_q.size() && sent_q[HDR + i] !== eb) bad_b++;
            if (i < rd_addr_q.size() && rd_addr_q[i] != (wp0 + i) % ENTRIES) bad_a++;
        end
        check({tag, "_bytes"}, bad_b, 0);
        check({tag, "_addrs"}, bad_a, 0);
    endtask

    task automatic verify_invalid(input string tag);
        check({tag, "_done_cyc"}, done_cyc, 1);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_busy_len"}, busy_cyc, 1);
        check({tag, "_no_rd"}, rd_cnt, 0);
        check({tag, "_no_trmt"}, trmt_cnt, 0);
    endtask

    initial begin
        int max_addr;
        rst_n          = 1'b0;
        bus.dump_start = 1'b0;
        bus.dump_chan  = 3'd0;
        bus.wr_ptr     = '0;
        bus.tx_done    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              32'({bus.ram_addr, bus.ch_rd_en, bus.tx_data, bus.trmt, bus.busy, bus.dump_done}),
              32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", 32'(bus.busy), 32'd0);

        // Full CH2 dump from address 0: bytes 0x00..0xFF, 0x00..0x7F.
        run_dump(3'd2, 0, 1, 0, 0);
        verify("ch2_wp0", 2, 0);
        if (sent_q.size() == ENTRIES + HDR)
            check("ch2_last_byte", 32'(sent_q[ENTRIES + HDR - 1]), 32'h7F);

        // CH5 starting near the top: wrap at 383 -> 0.
        run_dump(3'd5, 380, 1, 0, 0);
        verify("ch5_wp380", 5, 380);
        max_addr = 0;
        foreach (rd_addr_q[i]) if (rd_addr_q[i] > max_addr) max_addr = rd_addr_q[i];
        check("ch5_addr_max", max_addr, ENTRIES - 1);
        if (rd_addr_q.size() == ENTRIES) begin
            check("ch5_addr_0", rd_addr_q[0], 380);
            check("ch5_addr_4", rd_addr_q[4], 0);
            check("ch5_addr_last", rd_addr_q[ENTRIES - 1], 379);
        end

        // Invalid channels finish immediately.
        run_dump(3'd0, 5, 1, 0, 0);
        verify_invalid("chan0");
        run_dump(3'd6, 5, 1, 0, 0);
        verify_invalid("chan6");

        // Start during byte 10 ignored; tx_done held high for several cycles.
        run_dump(3'd2, 17, 5, 10, 0);
        verify("ch2_restart_hold", 2, 17);

        // Reset in the middle of byte 100, then a clean CH1 dump.
        run_dump(3'd4, 50, 1, 0, 100);
        check("abort_trmt_cnt", trmt_cnt, 100);
        run_dump(3'd1, 200, 1, 0, 0);
        verify("ch1_after_abort", 1, 200);

        // Out-of-range write pointer starts from 0.
        run_dump(3'd3, 400, 1, 0, 0);
        verify("ch3_wp400", 3, 400);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
